crop_window_ctrl: RTL and testbench

//  Frame-synchronous controller for the DVP crop stage. Accepts crop-window updates from the SoC

---
 rtl/crop_window_ctrl_pkg.sv | 66 ++++++
 rtl/crop_window_ctrl_if.sv | 21 ++
 rtl/crop_window_clamp.sv | 20 ++
 rtl/crop_window_ctrl.sv | 121 ++++++++++++
 tb/tb_crop_window_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/crop_window_ctrl_pkg.sv
// Shared types and constants for the frame-synchronous crop window controller.
// Includes the pan step helper used when CROP_PAN_EN is defined.
package crop_window_ctrl_pkg;

    localparam int XW         = 11;
    localparam int YW         = 11;
    localparam int DEF_H_DISP = 1280;
    localparam int DEF_V_DISP = 720;
    localparam int DEF_FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [XW-1:0] start_x;
        logic [YW-1:0] start_y;
        logic [XW-1:0] end_x;
        logic [YW-1:0] end_y;
    } win_t;

    typedef struct packed {
        logic [XW-1:0] s;
        logic [XW-1:0] e;
        logic          flip;
    } pan_t;

    function automatic win_t full_window(input int h, input int v);
        win_t w;
        w.start_x = '0;
        w.start_y = '0;
        w.end_x   = XW'(h);
        w.end_y   = YW'(v);
        return w;
    endfunction

    // Shift one axis by d (negated when neg), keeping its length; bounce off 0 and lim.
    function automatic pan_t pan_axis(input logic [XW-1:0] s, input logic [XW-1:0] e,
                                      input logic signed [7:0] d, input logic neg, input int lim);
        pan_t r;
        int   step;
        int   len;
        int   ns;
        int   ne;
        step   = neg ? -int'(d) : int'(d);
        len    = int'(e) - int'(s);
        ns     = int'(s) + step;
        ne     = int'(e) + step;
        r.flip = 1'b0;
        if (step < 0 && ns <= 0) begin
            ns     = 0;
            ne     = len;
            r.flip = 1'b1;
        end else if (step > 0 && ne >= lim) begin
            ne     = lim;
            ns     = lim - len;
            r.flip = 1'b1;
        end
        r.s = XW'(ns);
        r.e = XW'(ne);
        return r;
    endfunction

endpackage

// File: rtl/crop_window_ctrl_if.sv
// Config write channel from the CSR bridge: valid/ready plus the requested window.
interface crop_window_ctrl_if;

    logic                               cfg_valid;
    logic                               cfg_ready;
    logic [crop_window_ctrl_pkg::XW-1:0] cfg_start_x;
    logic [crop_window_ctrl_pkg::YW-1:0] cfg_start_y;
    logic [crop_window_ctrl_pkg::XW-1:0] cfg_end_x;
    logic [crop_window_ctrl_pkg::YW-1:0] cfg_end_y;

    modport master (
        output cfg_valid, cfg_start_x, cfg_start_y, cfg_end_x, cfg_end_y,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_start_x, cfg_start_y, cfg_end_x, cfg_end_y,
        output cfg_ready
    );

endinterface

// File: rtl/crop_window_clamp.sv
// Clamps the end coordinates to the display size and flags empty or inverted windows.
module crop_window_clamp
    import crop_window_ctrl_pkg::*;
#(
    parameter int H_DISP = DEF_H_DISP,
    parameter int V_DISP = DEF_V_DISP
) (
    input  win_t req,
    output win_t win,
    output logic err
);

    always_comb begin
        win = req;
        if (req.end_x > XW'(H_DISP)) win.end_x = XW'(H_DISP);
        if (req.end_y > YW'(V_DISP)) win.end_y = YW'(V_DISP);
        err = (win.start_x >= win.end_x) || (win.start_y >= win.end_y);
    end

endmodule

// File: rtl/crop_window_ctrl.sv
// Crop window controller: validated cfg writes land in a shadow set committed at vsync rise.
// Optional macro CROP_PAN_EN adds per-frame auto-panning with edge bounce.
module crop_window_ctrl
    import crop_window_ctrl_pkg::*;
#(
    parameter int H_DISP = DEF_H_DISP,
    parameter int V_DISP = DEF_V_DISP,
    parameter int FCNT_W = DEF_FCNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    crop_window_ctrl_if.slave  cfg,
    input  logic               vs_i,
`ifdef CROP_PAN_EN
    input  logic               pan_en,
    input  logic signed [7:0]  pan_dx,
    input  logic signed [7:0]  pan_dy,
`endif
    output logic [XW-1:0]      start_x,
    output logic [YW-1:0]      start_y,
    output logic [XW-1:0]      end_x,
    output logic [YW-1:0]      end_y,
    output logic               pending,
    output logic               cfg_err,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam win_t RESET_WIN = full_window(H_DISP, V_DISP);

    state_t state, state_nxt;
    win_t   live, shadow, staged, req, req_clamped;
    logic   req_err, vs_q, vs_rise, accept, good_wr, stage_vld;

    assign req           = '{start_x: cfg.cfg_start_x, start_y: cfg.cfg_start_y,
                             end_x: cfg.cfg_end_x, end_y: cfg.cfg_end_y};
    assign vs_rise       = vs_i & ~vs_q;
    assign cfg.cfg_ready = (state != COMMIT);
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    assign good_wr       = accept & ~req_err;

    crop_window_clamp #(.H_DISP(H_DISP), .V_DISP(V_DISP)) u_clamp (
        .req (req),
        .win (req_clamped),
        .err (req_err)
    );

`ifdef CROP_PAN_EN
    logic neg_x, neg_y;
    pan_t pan_x, pan_y;
    win_t pan_win;

    always_comb begin
        pan_x   = pan_axis(live.start_x, live.end_x, pan_dx, neg_x, H_DISP);
        pan_y   = pan_axis(XW'(live.start_y), XW'(live.end_y), pan_dy, neg_y, V_DISP);
        pan_win = '{start_x: pan_x.s, start_y: YW'(pan_y.s), end_x: pan_x.e, end_y: YW'(pan_y.e)};
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (good_wr) state_nxt = PEND;
            PEND:    if (vs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = stage_vld ? PEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vs_q      <= 1'b0;
            live      <= RESET_WIN;
            shadow    <= RESET_WIN;
            staged    <= RESET_WIN;
            stage_vld <= 1'b0;
            cfg_err   <= 1'b0;
            frame_cnt <= '0;
`ifdef CROP_PAN_EN
            neg_x     <= 1'b0;
            neg_y     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            vs_q    <= vs_i;
            cfg_err <= accept & req_err;
            if (vs_rise) frame_cnt <= frame_cnt + 1'b1;
            if (state == COMMIT) begin
                live      <= shadow;
                stage_vld <= 1'b0;
                if (stage_vld) shadow <= staged;
`ifdef CROP_PAN_EN
                neg_x     <= 1'b0;
                neg_y     <= 1'b0;
`endif
            end else if (good_wr) begin
                // A write racing the commit edge is parked so the old shadow still goes live.
                if (state == PEND && vs_rise) begin
                    staged    <= req_clamped;
                    stage_vld <= 1'b1;
                end else begin
                    shadow <= req_clamped;
                end
            end
`ifdef CROP_PAN_EN
            else if (pan_en && vs_rise && state == IDLE) begin
                live  <= pan_win;
                neg_x <= neg_x ^ pan_x.flip;
                neg_y <= neg_y ^ pan_y.flip;
            end
`endif
        end
    end

    assign start_x = live.start_x;
    assign start_y = live.start_y;
    assign end_x   = live.end_x;
    assign end_y   = live.end_y;
    assign pending = (state != IDLE);

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Directed bench for crop_window_ctrl: vector table for single writes plus hand-built races.
module tb_crop_window_ctrl;
    import crop_window_ctrl_pkg::*;

    typedef struct {
        bit do_wr;
        int sx, sy, ex, ey;
        bit do_vs;
        bit exp_err;
        bit exp_pend;
        int exp_sx, exp_sy, exp_ex, exp_ey;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   vs_i;
    logic [XW-1:0]          start_x, end_x;
    logic [YW-1:0]          start_y, end_y;
    logic                   pending, cfg_err;
    logic [DEF_FCNT_W-1:0]  frame_cnt;
`ifdef CROP_PAN_EN
    logic                   pan_en;
    logic signed [7:0]      pan_dx, pan_dy;
`endif

    int   checks = 0;
    int   errors = 0;
    int   fmodel = 0;
    int   cur_sx = 0, cur_sy = 0, cur_ex = 1280, cur_ey = 720;
    vec_t vecs[9];

    crop_window_ctrl_if bus();

    crop_window_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (bus),
        .vs_i      (vs_i),
`ifdef CROP_PAN_EN
        .pan_en    (pan_en),
        .pan_dx    (pan_dx),
        .pan_dy    (pan_dy),
`endif
        .start_x   (start_x),
        .start_y   (start_y),
        .end_x     (end_x),
        .end_y     (end_y),
        .pending   (pending),
        .cfg_err   (cfg_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkWin(input string name, input int sx, input int sy, input int ex, input int ey);
        checkOutput({name, ".start_x"}, int'(start_x), sx);
        checkOutput({name, ".start_y"}, int'(start_y), sy);
        checkOutput({name, ".end_x"}, int'(end_x), ex);
        checkOutput({name, ".end_y"}, int'(end_y), ey);
    endtask

    task automatic writeCfg(input int sx, input int sy, input int ex, input int ey);
        @(negedge clk);
        bus.cfg_valid   = 1'b1;
        bus.cfg_start_x = XW'(sx);
        bus.cfg_start_y = YW'(sy);
        bus.cfg_end_x   = XW'(ex);
        bus.cfg_end_y   = YW'(ey);
        @(negedge clk);
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic pulseVsync(input int hold);
        @(negedge clk);
        vs_i = 1'b1;
        repeat (hold) @(negedge clk);
        vs_i = 1'b0;
        repeat (2) @(negedge clk);
        fmodel++;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        if (v.do_wr) writeCfg(v.sx, v.sy, v.ex, v.ey);
        checkOutput({n, ".cfg_err"}, int'(cfg_err), int'(v.exp_err));
        checkOutput({n, ".pending"}, int'(pending), int'(v.exp_pend));
        checkWin({n, ".before_vs"}, cur_sx, cur_sy, cur_ex, cur_ey);
        if (v.do_vs) pulseVsync(3);
        checkWin({n, ".after_vs"}, v.exp_sx, v.exp_sy, v.exp_ex, v.exp_ey);
        checkOutput({n, ".pending_after"}, int'(pending), 0);
        checkOutput({n, ".frame_cnt"}, int'(frame_cnt), fmodel);
        cur_sx = v.exp_sx; cur_sy = v.exp_sy; cur_ex = v.exp_ex; cur_ey = v.exp_ey;
    endtask

    initial begin
        vecs[0] = '{1, 100,  50,  900, 600, 1, 0, 1, 100,  50,  900, 600};
        vecs[1] = '{1,  10,  20, 2000, 700, 1, 0, 1,  10,  20, 1280, 700};
        vecs[2] = '{1, 900,   0,  900, 100, 1, 1, 0,  10,  20, 1280, 700};
        vecs[3] = '{1,   0, 700,  500, 900, 1, 0, 1,   0, 700,  500, 720};
        vecs[4] = '{1,   5, 800,  100, 900, 1, 1, 0,   0, 700,  500, 720};
        vecs[5] = '{1,   0,   0,    1,   1, 1, 0, 1,   0,   0,    1,   1};
        vecs[6] = '{1,2047,   0, 2047,  10, 1, 1, 0,   0,   0,    1,   1};
        vecs[7] = '{0,   0,   0,    0,   0, 1, 0, 0,   0,   0,    1,   1};
        vecs[8] = '{1,1279, 719, 1280, 720, 1, 0, 1,1279, 719, 1280, 720};

        rst_n = 1'b0;
        vs_i  = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_start_x = '0; bus.cfg_start_y = '0; bus.cfg_end_x = '0; bus.cfg_end_y = '0;
`ifdef CROP_PAN_EN
        pan_en = 1'b0; pan_dx = '0; pan_dy = '0;
`endif
        repeat (3) @(negedge clk);
        checkWin("reset", 0, 0, 1280, 720);
        checkOutput("reset.pending", int'(pending), 0);
        checkOutput("reset.cfg_err", int'(cfg_err), 0);
        checkOutput("reset.frame_cnt", int'(frame_cnt), 0);
        checkOutput("reset.cfg_ready", int'(bus.cfg_ready), 1);
        rst_n = 1'b1;

        repeat (3) pulseVsync(4);
        checkWin("idle3", 0, 0, 1280, 720);
        checkOutput("idle3.frame_cnt", int'(frame_cnt), 3);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        // Two writes before one vsync: only the later one is committed.
        writeCfg(1, 2, 3, 4);
        writeCfg(11, 12, 13, 14);
        checkOutput("ab.pending", int'(pending), 1);
        pulseVsync(3);
        checkWin("ab.commit", 11, 12, 13, 14);

        // Write landing on the vsync edge while pending: A this frame, B next frame.
        writeCfg(20, 20, 40, 40);
        @(negedge clk);
        vs_i = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_start_x = 11'd30; bus.cfg_start_y = 11'd30; bus.cfg_end_x = 11'd60; bus.cfg_end_y = 11'd60;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        checkOutput("race.commit_ready", int'(bus.cfg_ready), 0);
        checkOutput("race.commit_pending", int'(pending), 1);
        checkWin("race.latency", 11, 12, 13, 14);
        @(negedge clk);
        checkWin("race.a_live", 20, 20, 40, 40);
        checkOutput("race.b_pending", int'(pending), 1);
        vs_i = 1'b0;
        fmodel++;
        repeat (2) @(negedge clk);
        pulseVsync(3);
        checkWin("race.b_live", 30, 30, 60, 60);
        checkOutput("race.b_done", int'(pending), 0);

        // Write on the vsync edge from IDLE waits for the next edge; long vsync counts once.
        @(negedge clk);
        vs_i = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_start_x = 11'd7; bus.cfg_start_y = 11'd8; bus.cfg_end_x = 11'd9; bus.cfg_end_y = 11'd10;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        fmodel++;
        checkOutput("idle_race.pending", int'(pending), 1);
        repeat (20) @(negedge clk);
        checkWin("idle_race.held", 30, 30, 60, 60);
        checkOutput("idle_race.frame_cnt", int'(frame_cnt), fmodel);
        vs_i = 1'b0;
        repeat (2) @(negedge clk);
        pulseVsync(3);
        checkWin("idle_race.commit", 7, 8, 9, 10);

        // Rejection flag is a single-cycle pulse.
        writeCfg(50, 50, 10, 10);
        checkOutput("err.pulse", int'(cfg_err), 1);
        @(negedge clk);
        checkOutput("err.clear", int'(cfg_err), 0);

        // Reset mid-frame drops the pending window.
        writeCfg(100, 100, 200, 200);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkWin("rst_mid", 0, 0, 1280, 720);
        checkOutput("rst_mid.pending", int'(pending), 0);
        checkOutput("rst_mid.frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        fmodel = 0;
        pulseVsync(3);
        checkWin("rst_mid.no_commit", 0, 0, 1280, 720);
        checkOutput("rst_mid.frame_after", int'(frame_cnt), fmodel);

`ifdef CROP_PAN_EN
        begin
            int exp_x[8] = '{100, 200, 300, 400, 500, 600, 640, 540};
            writeCfg(0, 0, 640, 360);
            pulseVsync(3);
            checkWin("pan.base", 0, 0, 640, 360);
            pan_en = 1'b1; pan_dx = 8'sd100; pan_dy = 8'sd0;
            for (int f = 0; f < 8; f++) begin
                pulseVsync(3);
                checkOutput($sformatf("pan%0d.start_x", f), int'(start_x), exp_x[f]);
                checkOutput($sformatf("pan%0d.end_x", f), int'(end_x), exp_x[f] + 640);
                checkOutput($sformatf("pan%0d.start_y", f), int'(start_y), 0);
            end
            pan_en = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
